mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage of the 4-thread pipeline. Sits directly downstream of the EX/MEM register and consumes its bundle.
//  Performs the data-memory load/store into a per-thread partitioned data RAM and registers the MEM/WB bundle.
//  Selects the write-back data from the load data or the ALU result.
//  Keeps per-thread load/store statistics counters, readable through a debug port.
// PARAMETERS
//  PROC_DATA_WIDTH        16  datapath/word width
//  PROC_REGFILE_LOG2_DEEP 5   register-file address width
//  DMEM_LOG2_DEEP         8   log2 words of data memory per thread
//  THREAD_ID_WIDTH        2   thread id width (4 threads)
//  STAT_CNT_WIDTH         16  width of each statistics counter
// PORTS
//  clk_i             in   1    clock
//  rst_i             in   1    reset: asynchronous, active-high
//  reg_write_en_i    in   1    from EX/MEM: write register file
//  mem_write_en_i    in   1    from EX/MEM: store
//  mem_read_en_i     in   1    from EX/MEM: load
//  mem_to_reg_i      in   1    from EX/MEM: write-back selects load data
//  alu_i             in   DW   from EX/MEM: ALU result / effective address
//  reg_data2_i       in   DW   from EX/MEM: store data
//  reg_write_addr_i  in   RW   from EX/MEM: destination register
//  thread_id_i       in   TW   from EX/MEM: issuing thread
//  reg_write_en_o    out  1    to WB: write enable (fault-qualified)
//  reg_write_addr_o  out  RW   to WB: destination register
//  wb_data_o         out  DW   to WB: write-back data
//  thread_id_o       out  TW   to WB: thread id
//  addr_fault_o      out  1    1-cycle pulse: out-of-range access was suppressed
//  stat_thread_sel_i in   TW   debug: selects which thread's counters are shown
//  stat_clr_i        in   1    debug: synchronous clear of all counters
//  stat_load_cnt_o   out  SW   debug: load count of the selected thread (combinational read)
//  stat_store_cnt_o  out  SW   debug: store count of the selected thread (combinational read)
// BEHAVIOUR
//  - Reset (async): all registered outputs = 0, addr_fault_o = 0, all counters = 0.
//    RAM contents are not reset and are retained across reset.
//  - RAM index = {thread_id_i, alu_i[DMEM_LOG2_DEEP-1:0]}. Each thread sees a private 2^DMEM_LOG2_DEEP-word space.
//  - Fault when (mem_read_en_i | mem_write_en_i) and alu_i[DW-1:DMEM_LOG2_DEEP] != 0.
//    Fault applies only when DW > DMEM_LOG2_DEEP; otherwise a fault never occurs.
//    On a fault:
//      - no RAM write;
//      - reg_write_en_o = 0 if the faulting op is a load;
//      - addr_fault_o = 1 in the cycle the bundle appears at the outputs;
//      - the access is not counted.
//  - Latency: 1 cycle. Inputs sampled at edge N appear on all WB outputs after edge N.
//    reg_write_addr_o and thread_id_o are passed through unchanged.
//  - Store: RAM written at edge N with reg_data2_i.
//  - Load: synchronous read at edge N. wb_data_o = mem_to_reg_q ? ram_rdata : alu_q
//    (combinational mux of registered values).
//  - Store at cycle N followed by a load to the same index at cycle N+1 returns the stored data.
//  - mem_write_en_i & mem_read_en_i both high (illegal encoding): write performed, read is write-first (returns reg_data2_i).
//  - Same word offset, different threads: the accesses never alias.
//  - Counters: per-thread load and store counters, incremented on each non-faulting access.
//    Saturate at 2^SW-1 (no wrap). stat_clr_i wins over a same-cycle increment.
//  - Reset asserted mid-operation: outputs clear immediately without waiting for a clock.
//    The first bundle after reset release appears after the first edge that samples rst_i = 0.
// STRUCTURE
//  - proc_pkg holds PROC_DATA_WIDTH, PROC_REGFILE_LOG2_DEEP, THREAD_ID_WIDTH, NUM_THREADS and the thread-id typedef,
//    shared with the EX/MEM and WB stages.
//  - Sub-module dmem_sp_ram: single-port synchronous RAM, write-first, no reset, parameterised width/depth.
//  - The MEM/WB register, fault logic and counters stay in this module.
// TESTING
//  1. Assert rst_i with no clock edge -> all outputs 0 immediately; counters read 0 for all threads.
//  2. T1 stores 0xBEEF at alu=0x0010, next cycle T1 loads alu=0x0010 with mem_to_reg=1, rd=5
//     -> after the load's edge: wb_data_o=0xBEEF, reg_write_addr_o=5, thread_id_o=1.
//  3. T0 stores 0x1111 at 0x0003 and T2 stores 0x2222 at 0x0003; then load from each thread
//     -> T0 load returns 0x1111, T2 load returns 0x2222 (no aliasing).
//  4. ALU op with mem_to_reg=0, alu=0x1234, reg_write_en=1 -> after 1 cycle wb_data_o=0x1234, reg_write_en_o=1.
//  5. Load at alu=0x0100 (DMEM_LOG2_DEEP=8) -> addr_fault_o pulses 1 cycle, reg_write_en_o=0,
//     RAM unchanged, T load counter unchanged.
//  6. Force T3 load counter to 0xFFFF and issue 3 more loads -> counter stays 0xFFFF.
//     Then assert stat_clr_i together with a load -> counter reads 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared pipeline parameters and types used by the EX/MEM, MEM/WB and WB stages.
package proc_pkg;

    localparam int unsigned PROC_DATA_WIDTH        = 16;
    localparam int unsigned PROC_REGFILE_LOG2_DEEP = 5;
    localparam int unsigned THREAD_ID_WIDTH        = 2;
    localparam int unsigned NUM_THREADS            = 1 << THREAD_ID_WIDTH;

    typedef logic [THREAD_ID_WIDTH-1:0] thread_id_t;

    // Registered MEM/WB bundle; wb data is muxed from alu or RAM read data after the register.
    typedef struct packed {
        logic                              reg_write_en;
        logic                              mem_to_reg;
        logic                              addr_fault;
        logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr;
        thread_id_t                        thread_id;
        logic [PROC_DATA_WIDTH-1:0]        alu;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bundle and MEM/WB -> WB outputs of the MEM stage.
interface mem_wb_stage_if;

    logic                                       reg_write_en_i;
    logic                                       mem_write_en_i;
    logic                                       mem_read_en_i;
    logic                                       mem_to_reg_i;
    logic [proc_pkg::PROC_DATA_WIDTH-1:0]        alu_i;
    logic [proc_pkg::PROC_DATA_WIDTH-1:0]        reg_data2_i;
    logic [proc_pkg::PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i;
    proc_pkg::thread_id_t                       thread_id_i;

    logic                                       reg_write_en_o;
    logic [proc_pkg::PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o;
    logic [proc_pkg::PROC_DATA_WIDTH-1:0]        wb_data_o;
    proc_pkg::thread_id_t                       thread_id_o;
    logic                                       addr_fault_o;

    modport master (
        output reg_write_en_i, mem_write_en_i, mem_read_en_i, mem_to_reg_i,
               alu_i, reg_data2_i, reg_write_addr_i, thread_id_i,
        input  reg_write_en_o, reg_write_addr_o, wb_data_o, thread_id_o, addr_fault_o
    );

    modport slave (
        input  reg_write_en_i, mem_write_en_i, mem_read_en_i, mem_to_reg_i,
               alu_i, reg_data2_i, reg_write_addr_i, thread_id_i,
        output reg_write_en_o, reg_write_addr_o, wb_data_o, thread_id_o, addr_fault_o
    );

endinterface

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous data RAM, write-first, contents not reset.
module dmem_sp_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
                rdata_o     <= wdata_i;
            end else begin
                rdata_o     <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: per-thread partitioned data RAM access, MEM/WB register, address-fault
// suppression and per-thread load/store statistics.
module mem_wb_stage
    import proc_pkg::*;
#(
    parameter int unsigned DMEM_LOG2_DEEP = 8,
    parameter int unsigned STAT_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    mem_wb_stage_if.slave             bus,
    input  thread_id_t                stat_thread_sel_i,
    input  logic                      stat_clr_i,
    output logic [STAT_CNT_WIDTH-1:0] stat_load_cnt_o,
    output logic [STAT_CNT_WIDTH-1:0] stat_store_cnt_o
);

    localparam int unsigned DW     = PROC_DATA_WIDTH;
    localparam int unsigned RAM_AW = THREAD_ID_WIDTH + DMEM_LOG2_DEEP;

    logic              access_c;
    logic              fault_c;
    logic [RAM_AW-1:0] ram_addr_c;
    logic [DW-1:0]     ram_rdata;
    mem_wb_t           wb_q;

    logic [STAT_CNT_WIDTH-1:0] ld_cnt_q [NUM_THREADS];
    logic [STAT_CNT_WIDTH-1:0] st_cnt_q [NUM_THREADS];

    assign access_c   = bus.mem_read_en_i | bus.mem_write_en_i;
    assign ram_addr_c = {bus.thread_id_i, bus.alu_i[DMEM_LOG2_DEEP-1:0]};

    // Any set address bit above the per-thread window is out of range.
    generate
        if (DW > DMEM_LOG2_DEEP) begin : g_fault
            assign fault_c = access_c & (|bus.alu_i[DW-1:DMEM_LOG2_DEEP]);
        end else begin : g_no_fault
            assign fault_c = 1'b0;
        end
    endgenerate

    dmem_sp_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (RAM_AW)
    ) u_dmem (
        .clk_i   (clk_i),
        .en_i    (access_c & ~fault_c),
        .we_i    (bus.mem_write_en_i),
        .addr_i  (ram_addr_c),
        .wdata_i (bus.reg_data2_i),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_q <= '0;
        end else begin
            wb_q.reg_write_en   <= bus.reg_write_en_i & ~(fault_c & bus.mem_read_en_i);
            wb_q.mem_to_reg     <= bus.mem_to_reg_i;
            wb_q.addr_fault     <= fault_c;
            wb_q.reg_write_addr <= bus.reg_write_addr_i;
            wb_q.thread_id      <= bus.thread_id_i;
            wb_q.alu            <= bus.alu_i;
        end
    end

    assign bus.reg_write_en_o   = wb_q.reg_write_en;
    assign bus.reg_write_addr_o = wb_q.reg_write_addr;
    assign bus.thread_id_o      = wb_q.thread_id;
    assign bus.addr_fault_o     = wb_q.addr_fault;
    assign bus.wb_data_o        = wb_q.mem_to_reg ? ram_rdata : wb_q.alu;

    // Saturating per-thread counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                ld_cnt_q[t] <= '0;
                st_cnt_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (stat_clr_i) begin
                    ld_cnt_q[t] <= '0;
                    st_cnt_q[t] <= '0;
                end else if (!fault_c && bus.thread_id_i == THREAD_ID_WIDTH'(t)) begin
                    if (bus.mem_read_en_i && ld_cnt_q[t] != '1) begin
                        ld_cnt_q[t] <= ld_cnt_q[t] + STAT_CNT_WIDTH'(1);
                    end
                    if (bus.mem_write_en_i && st_cnt_q[t] != '1) begin
                        st_cnt_q[t] <= st_cnt_q[t] + STAT_CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign stat_load_cnt_o  = ld_cnt_q[stat_thread_sel_i];
    assign stat_store_cnt_o = st_cnt_q[stat_thread_sel_i];

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: randomized and directed traffic against a behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    bit          clk_run = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        clr;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (bus.slave),
        .stat_thread_sel_i (sel),
        .stat_clr_i        (clr),
        .stat_load_cnt_o   (ld_cnt),
        .stat_store_cnt_o  (st_cnt)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        bit          rwe;
        logic [4:0]  addr;
        logic [1:0]  tid;
        bit          fault;
        bit          chk_data;
        logic [15:0] data;
        int          ld;
        int          st;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    logic [15:0] mem_m   [4][256];
    bit          known_m [4][256];
    int          ld_m    [4];
    int          st_m    [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one bundle appears per clock while enabled.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                chk("reg_write_en", 32'(bus.reg_write_en_o), 32'(e.rwe));
                chk("reg_write_addr", 32'(bus.reg_write_addr_o), 32'(e.addr));
                chk("thread_id", 32'(bus.thread_id_o), 32'(e.tid));
                chk("addr_fault", 32'(bus.addr_fault_o), 32'(e.fault));
                if (e.chk_data) chk("wb_data", 32'(bus.wb_data_o), 32'(e.data));
                chk("stat_load", 32'(ld_cnt), 32'(e.ld));
                chk("stat_store", 32'(st_cnt), 32'(e.st));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Drive one bundle (call at posedge+2), push its expected result, advance one cycle.
    task automatic drive(input bit rwe, input bit wr, input bit rd, input bit m2r,
                         input logic [15:0] alu, input logic [15:0] wdata,
                         input logic [4:0] rda, input logic [1:0] tid,
                         input logic [1:0] s, input bit c);
        exp_t e;
        bit   fault;
        int   idx;
        bus.reg_write_en_i   = rwe;
        bus.mem_write_en_i   = wr;
        bus.mem_read_en_i    = rd;
        bus.mem_to_reg_i     = m2r;
        bus.alu_i            = alu;
        bus.reg_data2_i      = wdata;
        bus.reg_write_addr_i = rda;
        bus.thread_id_i      = tid;
        sel                  = s;
        clr                  = c;

        fault = (rd || wr) && (alu >= 16'd256);
        idx   = int'(alu % 256);
        e.rwe   = rwe && !(fault && rd);
        e.addr  = rda;
        e.tid   = tid;
        e.fault = fault;
        e.data  = '0;
        if (!m2r) begin
            e.chk_data = 1'b1;
            e.data     = alu;
        end else if (rd && !fault && wr) begin
            e.chk_data = 1'b1;
            e.data     = wdata;
        end else if (rd && !fault && known_m[tid][idx]) begin
            e.chk_data = 1'b1;
            e.data     = mem_m[tid][idx];
        end else begin
            e.chk_data = 1'b0;
        end
        if (wr && !fault) begin
            mem_m[tid][idx]   = wdata;
            known_m[tid][idx] = 1'b1;
        end
        if (c) begin
            for (int t = 0; t < 4; t++) begin
                ld_m[t] = 0;
                st_m[t] = 0;
            end
        end else if (!fault) begin
            if (rd) ld_m[tid] = sat_inc(ld_m[tid]);
            if (wr) st_m[tid] = sat_inc(st_m[tid]);
        end
        e.ld = ld_m[s];
        e.st = st_m[s];
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.reg_write_en_i   = 1'b0;
        bus.mem_write_en_i   = 1'b0;
        bus.mem_read_en_i    = 1'b0;
        bus.mem_to_reg_i     = 1'b0;
        bus.alu_i            = '0;
        bus.reg_data2_i      = '0;
        bus.reg_write_addr_i = '0;
        bus.thread_id_i      = '0;
        clr                  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rwe"}, 32'(bus.reg_write_en_o), 32'(0));
        chk({tag, "_raddr"}, 32'(bus.reg_write_addr_o), 32'(0));
        chk({tag, "_wbdata"}, 32'(bus.wb_data_o), 32'(0));
        chk({tag, "_tid"}, 32'(bus.thread_id_o), 32'(0));
        chk({tag, "_fault"}, 32'(bus.addr_fault_o), 32'(0));
        for (int t = 0; t < 4; t++) begin
            sel = 2'(t);
            #1;
            chk({tag, "_ldcnt"}, 32'(ld_cnt), 32'(0));
            chk({tag, "_stcnt"}, 32'(st_cnt), 32'(0));
        end
    endtask

    task automatic rand_txn();
        int          kind;
        bit          wr, rd, m2r;
        logic [15:0] alu;
        kind = int'($urandom_range(0, 9));
        rd   = (kind <= 3) || (kind == 7);
        wr   = (kind >= 4 && kind <= 7);
        m2r  = rd || ($urandom_range(0, 9) == 0);
        alu  = 16'($urandom_range(0, 31));
        if ($urandom_range(0, 99) < 15) alu[15:8] = 8'($urandom_range(1, 255));
        drive(1'($urandom_range(0, 1)), wr, rd, m2r, alu, 16'($urandom),
              5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
    endtask

    initial begin
        for (int t = 0; t < 4; t++) begin
            ld_m[t] = 0;
            st_m[t] = 0;
            for (int i = 0; i < 256; i++) known_m[t][i] = 1'b0;
        end
        rst = 1'b0;
        sel = '0;
        idle_inputs();

        // Reset with no clock running: outputs clear asynchronously.
        #3 rst = 1'b1;
        #1 check_reset_state("async_reset");
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #2 mon_en = 1'b1;

        // Store then immediate load, same thread.
        drive(0, 1, 0, 0, 16'h0010, 16'hBEEF, 5'd0, 2'd1, 2'd1, 0);
        drive(1, 0, 1, 1, 16'h0010, 16'h0000, 5'd5, 2'd1, 2'd1, 0);
        // Same offset in two threads must not alias.
        drive(0, 1, 0, 0, 16'h0003, 16'h1111, 5'd0, 2'd0, 2'd0, 0);
        drive(0, 1, 0, 0, 16'h0003, 16'h2222, 5'd0, 2'd2, 2'd2, 0);
        drive(1, 0, 1, 1, 16'h0003, 16'h0000, 5'd1, 2'd0, 2'd0, 0);
        drive(1, 0, 1, 1, 16'h0003, 16'h0000, 5'd2, 2'd2, 2'd2, 0);
        // Plain ALU result write-back.
        drive(1, 0, 0, 0, 16'h1234, 16'h0000, 5'd7, 2'd0, 2'd0, 0);
        // Out-of-range load and store are suppressed and not counted.
        drive(1, 0, 1, 1, 16'h0100, 16'h0000, 5'd9, 2'd1, 2'd1, 0);
        drive(1, 1, 0, 0, 16'h0110, 16'hDEAD, 5'd9, 2'd1, 2'd1, 0);
        drive(1, 0, 1, 1, 16'h0010, 16'h0000, 5'd9, 2'd1, 2'd1, 0);
        // Illegal read+write encoding returns the written data.
        drive(1, 1, 1, 1, 16'h0020, 16'hA5A5, 5'd3, 2'd3, 2'd3, 0);

        repeat (2000) rand_txn();

        // Reset in mid-traffic: outputs and counters clear without a clock edge.
        mon_en = 1'b0;
        idle_inputs();
        #1 rst = 1'b1;
        #1 check_reset_state("mid_reset");
        chk("mid_reset_sb_empty", 32'(sb_q.size()), 32'(0));
        for (int t = 0; t < 4; t++) begin
            ld_m[t] = 0;
            st_m[t] = 0;
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #2 mon_en = 1'b1;

        // RAM contents survive reset.
        drive(1, 0, 1, 1, 16'h0010, 16'h0000, 5'd4, 2'd1, 2'd1, 0);
        repeat (200) rand_txn();

        // Drive thread 3 load counter into saturation, then clear alongside a load.
        drive(0, 0, 0, 0, 16'h0000, 16'h0000, 5'd0, 2'd0, 2'd3, 1);
        for (int i = 0; i < 65535 + 3; i++) begin
            drive(1, 0, 1, 1, 16'($urandom_range(0, 255)), 16'h0000, 5'd1, 2'd3, 2'd3, 0);
        end
        drive(1, 0, 1, 1, 16'h0005, 16'h0000, 5'd1, 2'd3, 2'd3, 1);
        drive(1, 0, 1, 1, 16'h0005, 16'h0000, 5'd1, 2'd3, 2'd3, 0);

        mon_en = 1'b0;
        chk("final_sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
